// File: rtl/reg_file_wb.sv
// 32-entry MIPS register file: two combinational read ports, one decoded-select write
// port, hardwired-zero $0, same-cycle WB-to-ID write-through bypass, and a sticky write-select error flag.
module reg_file_wb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REGS-1:0]   wr_sel,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  wr_err
);

  localparam int unsigned SEL_W = 1 << ADDR_WIDTH;
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [SEL_W-1:0]      sel_ext;
  logic [SEL_W-1:0]      sel_exp;
  logic                  bypass_ok;
  logic                  err_set;

  // Select padded to the full address space so wr_addr can index it without going out of range.
  assign sel_ext   = SEL_W'(wr_sel);
  assign sel_exp   = SEL_W'(1) << wr_addr;
  assign bypass_ok = rst_n && sel_ext[wr_addr] && (wr_addr != '0);
  assign err_set   = (wr_sel != '0) && (sel_ext != sel_exp);

  // Register array and sticky error; reg 0 is only ever cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wr_data;
        end
      end
      if (err_set) begin
        wr_err <= 1'b1;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (!rst_n) begin
      val = '0;
    end else if (bypass_ok && (addr == wr_addr)) begin
      val = wr_data;
    end else if ((addr != '0) && (32'(addr) < NUM_REGS)) begin
      val = regs[IDX_W'(addr)];
    end
    return val;
  endfunction

  // Read ports are combinational so ID sees operands in the same cycle.
  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32-entry general-purpose register file for the 5-stage MIPS pipeline.
- Sits directly downstream of the 5-to-32 write-address decoder. It consumes the one-hot write-select produced from the WB-stage destination register and write enable, and supplies operands to the ID stage.
- Provides two combinational read ports (rs, rt), one synchronous write port, a hardwired-zero $0, and same-cycle WB-to-ID write-through bypass. This bypass removes the need for half-cycle clocking.

Parameters:
- DATA_WIDTH, 32, register and data-bus width in bits.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of implemented registers. Must be ≤ 2^ADDR_WIDTH and ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_sel  input  NUM_REGS  one-hot write select from the decoder. All-zero means no write.
- wr_addr  input  ADDR_WIDTH  binary WB destination, the same value the decoder was fed. Used for bypass compare only.
- wr_data  input  DATA_WIDTH  WB result.
- rs_addr  input  ADDR_WIDTH  read port A address.
- rt_addr  input  ADDR_WIDTH  read port B address.
- rs_data  output  DATA_WIDTH  read port A data.
- rt_data  output  DATA_WIDTH  read port B data.
- wr_err  output  1  sticky flag: wr_sel was seen with more than one bit set, or wr_sel disagreed with wr_addr.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NUM_REGS registers clear to 0.
  - wr_err clears to 0.
  - While rst_n is low, rs_data and rt_data read 0 and bypass is suppressed.
- Write:
  - On the rising clk edge, for every i ≥ 1 with wr_sel[i]=1, reg[i] <= wr_data.
  - wr_sel[0] is ignored; reg[0] stays 0 forever.
  - No write occurs when wr_sel is all-zero.
- Read (combinational, zero latency):
  - Address 0 returns 0.
  - An address ≥ NUM_REGS returns 0.
  - Otherwise the port returns reg[addr].
- Bypass:
  - If wr_sel[wr_addr]=1, wr_addr≠0, and rs_addr==wr_addr, then rs_data = wr_data in the same cycle, before the edge commits the write.
  - The same rule applies independently to rt.
  - Both ports may bypass simultaneously, including when rs_addr==rt_addr.
- Multi-hot wr_sel (illegal):
  - All selected registers except reg 0 are written with wr_data.
  - Bypass keys only on wr_addr.
  - wr_err sets on the next edge and holds until reset.
- Mismatch: if wr_sel is nonzero and wr_sel ≠ (1<<wr_addr), wr_err sets on the next edge.
- Write to a register ≥ NUM_REGS: discarded, no error raised.
- Reset mid-operation: a write coincident with the rst_n falling edge is lost. The first write accepted is on the first rising edge after rst_n goes high.
- No other state exists. The block never stalls and has no handshake; the pipeline must hold wr_sel at zero on bubbles.

Test Plan:
- Reset, then read all 32 addresses on both ports → every value is 0x00000000 and wr_err=0.
- wr_sel=1<<5, wr_addr=5, wr_data=0xDEADBEEF for one cycle; next cycle rs_addr=5, rt_addr=5 → both ports read 0xDEADBEEF.
- Bypass: in the same cycle, write reg 9 with 0x12345678 while rs_addr=9 and reg 9 holds 0x1 → rs_data=0x12345678 combinationally; after the edge, reg 9 = 0x12345678.
- Write $0: wr_sel=1, wr_addr=0, wr_data=0xFFFFFFFF; also rs_addr=0 that cycle → rs_data=0 that cycle and after; wr_err stays 0.
- Illegal: wr_sel=0x00000006 with wr_addr=1 → regs 1 and 2 both written, and wr_err=1 after the edge and after 10 further idle cycles; rst_n pulse → wr_err=0 and regs 1 and 2 read 0.
- Async reset: assert rst_n low mid-cycle between edges after loading regs 1–31 → rs_data/rt_data drop to 0 immediately; a write pending at the next edge is not committed.
